// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG entropy harvester.
//   state_t      : harvester FSM states
//   RUN_W        : width of the repetition-count run counter
//   *_MIN/*_MAX  : legal parameter ranges checked at elaboration
package trng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam int unsigned RUN_W = 8;

  localparam int unsigned N_CH_MIN   = 1;
  localparam int unsigned N_CH_MAX   = 16;
  localparam int unsigned WORD_W_MIN = 2;
  localparam int unsigned WORD_W_MAX = 32;
  localparam int unsigned REP_MIN    = 2;
  localparam int unsigned REP_MAX    = 255;
  localparam int unsigned SYNC_MIN   = 2;
  localparam int unsigned SYNC_MAX   = 4;

endpackage

// File: rtl/trng_harvester_if.sv
// Random-word stream between the harvester and its consumer.
//   rnd_data  : assembled random word (producer -> consumer)
//   rnd_valid : word available        (producer -> consumer)
//   rnd_ready : consumer accepts word (consumer -> producer)
interface trng_harvester_if #(
  parameter int unsigned WORD_W = 8
);

  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);

endinterface

// File: rtl/trng_rep_test.sv
// Continuous repetition-count health test on the raw entropy bit.
//   clk, rst_n : clock, async active-low reset
//   clr        : clears run counter and alarm (harvester idle/disabled)
//   raw        : raw combined entropy bit, one per cycle
//   alarm      : sticky health failure, registered
//   hit_c      : run counter has reached REP_LIMIT this cycle (combinational)
module trng_rep_test
  import trng_pkg::*;
#(
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic raw,
  output logic alarm,
  output logic hit_c
);

  logic [RUN_W-1:0] run_q;
  logic             prev_q;

  // Alarm sets on the edge after the counter reaches the limit; the harvester
  // uses hit_c to enter FAIL on that same edge.
  assign hit_c = !clr && (run_q >= RUN_W'(REP_LIMIT));

  // Run counter (saturating), previous-bit tracker and sticky alarm.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q  <= '0;
      prev_q <= 1'b0;
      alarm  <= 1'b0;
    end else begin
      prev_q <= raw;
      if (clr) begin
        run_q <= '0;
        alarm <= 1'b0;
      end else begin
        // A zero count means no previous sample is valid yet: start a new run.
        if ((run_q != '0) && (raw == prev_q)) begin
          if (run_q != '1) run_q <= run_q + 1'b1;
        end else begin
          run_q <= RUN_W'(1);
        end
        if (hit_c) alarm <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trng_harvester.sv
// Entropy harvester: synchronises N_CH asynchronous entropy cells, XORs the
// enabled channels into one raw bit per cycle, optionally von Neumann debiases
// it, runs a repetition-count health test and packs bits into WORD_W words.
// Optional feature macro: TRNG_VN_EN (von Neumann debiasing on raw pairs).
//   clk, rst_n : clock, async active-low reset
//   en         : harvest enable; low forces IDLE and clears alarm
//   ent_in     : raw asynchronous entropy cell outputs
//   ch_mask    : 1 = channel contributes to the XOR
//   stream     : rnd_data / rnd_valid / rnd_ready word handshake (master)
//   alarm      : sticky health-test failure
module trng_harvester
  import trng_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned WORD_W      = 8,
  parameter int unsigned REP_LIMIT   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_CH-1:0]       ent_in,
  input  logic [N_CH-1:0]       ch_mask,
  trng_harvester_if.master      stream,
  output logic                  alarm
);

  localparam int unsigned CNT_W = $clog2(WORD_W) + 1;

  if ((N_CH < N_CH_MIN) || (N_CH > N_CH_MAX) ||
      (WORD_W < WORD_W_MIN) || (WORD_W > WORD_W_MAX) ||
      (REP_LIMIT < REP_MIN) || (REP_LIMIT > REP_MAX) ||
      (SYNC_STAGES < SYNC_MIN) || (SYNC_STAGES > SYNC_MAX)) begin : g_param_err
    $error("trng_harvester: parameter out of range");
  end

  logic [N_CH-1:0] sync;
  logic            raw_q;

  // Per-channel synchroniser chains into the clk domain.
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_sync
    logic [SYNC_STAGES-1:0] sh;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sh <= '0;
      else        sh <= {sh[SYNC_STAGES-2:0], ent_in[ch]};
    end
    assign sync[ch] = sh[SYNC_STAGES-1];
  end

  // Raw bit: XOR of the enabled synchronised channels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) raw_q <= 1'b0;
    else        raw_q <= ^(sync & ch_mask);
  end

  state_t state_q, state_n;
  logic   hit_c;
  logic   rep_clr;

  assign rep_clr = !en || (state_q == IDLE);

  trng_rep_test #(.REP_LIMIT(REP_LIMIT)) u_rep (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rep_clr),
    .raw   (raw_q),
    .alarm (alarm),
    .hit_c (hit_c)
  );

  logic [WORD_W-1:0] acc_q, acc_n;
  logic [WORD_W-1:0] data_q, data_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              valid_q, valid_n;
  logic              bit_ok;
  logic              bit_v;
`ifdef TRNG_VN_EN
  logic              phase_q, phase_n;
  logic              first_q, first_n;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
`ifdef TRNG_VN_EN
      phase_q <= 1'b0;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      data_q  <= data_n;
      cnt_q   <= cnt_n;
      valid_q <= valid_n;
`ifdef TRNG_VN_EN
      phase_q <= phase_n;
      first_q <= first_n;
`endif
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    data_n  = data_q;
    cnt_n   = cnt_q;
    valid_n = valid_q;
    bit_ok  = 1'b0;
    bit_v   = raw_q;
`ifdef TRNG_VN_EN
    phase_n = phase_q;
    first_n = first_q;
`endif

    unique case (state_q)
      IDLE: begin
        acc_n   = '0;
        data_n  = '0;
        cnt_n   = '0;
        valid_n = 1'b0;
`ifdef TRNG_VN_EN
        phase_n = 1'b0;
`endif
        if (en) state_n = FILL;
      end

      FILL: begin
        if (hit_c) begin
          state_n = FAIL;
          data_n  = '0;
          valid_n = 1'b0;
        end else begin
`ifdef TRNG_VN_EN
          // First bit of a pair is stored; 01 -> 0, 10 -> 1, equal pairs drop.
          phase_n = !phase_q;
          if (!phase_q) begin
            first_n = raw_q;
          end else if (first_q != raw_q) begin
            bit_ok = 1'b1;
            bit_v  = first_q;
          end
`else
          bit_ok = 1'b1;
`endif
          if (bit_ok) begin
            acc_n = {acc_q[WORD_W-2:0], bit_v};
            if (cnt_q == CNT_W'(WORD_W - 1)) begin
              data_n  = acc_n;
              valid_n = 1'b1;
              cnt_n   = '0;
              state_n = FULL;
            end else begin
              cnt_n = cnt_q + 1'b1;
            end
          end
        end
      end

      FULL: begin
        if (hit_c) begin
          state_n = FAIL;
          data_n  = '0;
          valid_n = 1'b0;
        end else if (valid_q && stream.rnd_ready) begin
          state_n = FILL;
          valid_n = 1'b0;
          cnt_n   = '0;
`ifdef TRNG_VN_EN
          phase_n = 1'b0;
`endif
        end
      end

      FAIL: begin
        data_n  = '0;
        valid_n = 1'b0;
      end

      default: state_n = IDLE;
    endcase

    // Disable wins over everything and drops any pending word.
    if (!en) begin
      state_n = IDLE;
      valid_n = 1'b0;
      data_n  = '0;
      acc_n   = '0;
      cnt_n   = '0;
`ifdef TRNG_VN_EN
      phase_n = 1'b0;
`endif
    end
  end

  assign stream.rnd_data  = data_q;
  assign stream.rnd_valid = valid_q;

endmodule

// File: tb/tb_trng_harvester.sv
// Directed self-checking bench for trng_harvester (N_CH=4, WORD_W=8,
// REP_LIMIT=16, SYNC_STAGES=2). Inputs change 1 time unit after posedge and
// outputs are sampled at that same point, so values seen after edge k reflect
// ent_in driven after edge k-3 (two sync flops plus the raw register).
module tb_trng_harvester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] ent_in;
  logic [3:0] ch_mask;
  logic       alarm;

  int n_tests = 0;
  int n_fail  = 0;

  trng_harvester_if #(.WORD_W(8)) bus ();

  trng_harvester #(
    .N_CH        (4),
    .WORD_W      (8),
    .REP_LIMIT   (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .ent_in  (ent_in),
    .ch_mask (ch_mask),
    .stream  (bus.master),
    .alarm   (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  pat;
  logic [15:0] hist;
  logic [15:0] pm;
  logic        r1;
  logic        exp_raw;

  initial begin
    rst_n = 1'b1;
    en = 1'b0;
    ent_in = 4'b0000;
    ch_mask = 4'b0001;
    bus.rnd_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(bus.rnd_valid), 32'd0);
    check("rst_data",  32'(bus.rnd_data),  32'd0);
    check("rst_alarm", 32'(alarm),         32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

`ifndef TRNG_VN_EN
    // Word 1,0,1,1,0,0,1,0 -> 0xB2 held 20 cycles, one-cycle ready, then 0x55.
    pat = 8'hB2;
    ch_mask = 4'b0001;
    for (int c = 0; c <= 39; c++) begin
      ent_in = {3'b000, (c < 8) ? pat[7-c] : ((c % 2) == 0)};
      en = (c >= 2);
      bus.rnd_ready = (c == 31);
      tick();
      if (c == 9)  check("b2_not_early", 32'(bus.rnd_valid), 32'd0);
      if (c == 10) check("b2_valid",     32'(bus.rnd_valid), 32'd1);
      if (c == 10) check("b2_data",      32'(bus.rnd_data),  32'hB2);
      if (c == 20) check("b2_hold_data", 32'(bus.rnd_data),  32'hB2);
      if (c == 30) check("b2_hold_vld",  32'(bus.rnd_valid), 32'd1);
      if (c == 30) check("b2_hold_end",  32'(bus.rnd_data),  32'hB2);
      if (c == 31) check("hs_valid_low", 32'(bus.rnd_valid), 32'd0);
      if (c == 38) check("w55_not_early", 32'(bus.rnd_valid), 32'd0);
      if (c == 39) check("w55_valid",    32'(bus.rnd_valid), 32'd1);
      if (c == 39) check("w55_data",     32'(bus.rnd_data),  32'h55);
      if (c == 39) check("w55_alarm",    32'(alarm),         32'd0);
    end

    // Word 0xDB, handshake, 5 more bits, then async reset mid-word.
    for (int c = 0; c <= 16; c++) begin
      ent_in = {3'b000, ((c % 3) != 2)};
      en = (c >= 2);
      bus.rnd_ready = (c == 11);
      tick();
      if (c == 10) check("db_data", 32'(bus.rnd_data), 32'hDB);
    end
    rst_n = 1'b0;
    #1;
    check("midrst_data",  32'(bus.rnd_data),  32'd0);
    check("midrst_valid", 32'(bus.rnd_valid), 32'd0);
    check("midrst_alarm", 32'(alarm),         32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 1'b0;
    bus.rnd_ready = 1'b0;
    pat = 8'h69;
    for (int c = 0; c <= 10; c++) begin
      ent_in = {3'b000, (c < 8) ? pat[7-c] : ((c % 2) == 0)};
      en = (c >= 2);
      tick();
      if (c == 9)  check("fresh_not_early", 32'(bus.rnd_valid), 32'd0);
      if (c == 10) check("fresh_valid",     32'(bus.rnd_valid), 32'd1);
      if (c == 10) check("fresh_data",      32'(bus.rnd_data),  32'h69);
    end
`else
    // Von Neumann: pairs 01 -> 0x00, pairs 10 -> 0xFF, 11/00 pairs -> nothing.
    ch_mask = 4'b0001;
    bus.rnd_ready = 1'b1;
    for (int c = 0; c <= 18; c++) begin
      ent_in = {3'b000, ((c % 2) == 1)};
      en = (c >= 2);
      tick();
      if (c == 17) check("vn01_not_early", 32'(bus.rnd_valid), 32'd0);
      if (c == 18) check("vn01_valid",     32'(bus.rnd_valid), 32'd1);
      if (c == 18) check("vn01_data",      32'(bus.rnd_data),  32'h00);
    end
    for (int c = 0; c <= 18; c++) begin
      ent_in = {3'b000, ((c % 2) == 0)};
      en = (c >= 2);
      tick();
      if (c == 18) check("vn10_valid", 32'(bus.rnd_valid), 32'd1);
      if (c == 18) check("vn10_data",  32'(bus.rnd_data),  32'hFF);
    end
    for (int c = 0; c <= 40; c++) begin
      ent_in = {3'b000, ((c % 4) < 2)};
      en = (c >= 2);
      tick();
      if (c == 20) check("vn_eq_mid", 32'(bus.rnd_valid), 32'd0);
      if (c == 40) check("vn_eq_end", 32'(bus.rnd_valid), 32'd0);
      if (c == 40) check("vn_eq_alm", 32'(alarm),         32'd0);
    end
    bus.rnd_ready = 1'b0;
`endif

    // Mask 1010, ch3 held 1: raw = ~ent_in[1] three samples back.
    en = 1'b0;
    ch_mask = 4'b1010;
    pm = 16'b0110_1011_0010_1101;
    hist = '0;
    for (int c = 0; c <= 13; c++) begin
      r1 = pm[c];
      hist[c] = r1;
      ent_in = {1'b1, 1'($urandom()), r1, 1'($urandom())};
      tick();
      if (c >= 2) begin
        exp_raw = ~hist[c-2];
        check("mask_raw", 32'(dut.raw_q), 32'(exp_raw));
      end
    end

    // All-zero mask: raw stuck at 0 trips the repetition test.
    ch_mask = 4'b0000;
    for (int c = 0; c <= 19; c++) begin
      ent_in = {1'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom())};
      en = 1'b1;
      tick();
      if (c == 15) check("alarm_low_early", 32'(alarm), 32'd0);
      if (c == 16) check("alarm_low_limit", 32'(alarm), 32'd0);
`ifndef TRNG_VN_EN
      if (c == 16) check("zero_word_valid", 32'(bus.rnd_valid), 32'd1);
`endif
      if (c == 17) check("alarm_set",       32'(alarm),           32'd1);
      if (c == 17) check("fail_valid",      32'(bus.rnd_valid),   32'd0);
      if (c == 17) check("fail_data",       32'(bus.rnd_data),    32'd0);
      if (c == 17) check("fail_state",      32'(dut.state_q),     32'd3);
      if (c == 19) check("alarm_sticky",    32'(alarm),           32'd1);
    end
    en = 1'b0;
    tick();
    check("alarm_clr", 32'(alarm), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trng_harvester.md
# trng_harvester

Parametrised entropy harvester for the TRNG tile. It takes N_CH free-running asynchronous entropy cells (metastable RS/latch cells or ring oscillators), synchronises them into the clk domain and XOR-combines the enabled channels into one raw bit per cycle. The raw stream is optionally von Neumann debiased, checked by a continuous repetition-count health test, and packed into WORD_W-bit words delivered over a valid/ready handshake. It sits between the entropy-cell array and the tile's output pins or readout logic.

## Interface
- N_CH, 4: number of entropy channels (1..16)
- WORD_W, 8: output word width (2..32)
- REP_LIMIT, 16: run length of identical raw bits that raises the alarm (2..255)
- SYNC_STAGES, 2: synchroniser flops per channel (2..4)
- clk  input  1  system clock; all state on posedge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  harvest enable; low forces IDLE and clears alarm
- ent_in  input  N_CH  raw asynchronous entropy cell outputs
- ch_mask  input  N_CH  1 = channel contributes to the XOR
- rnd_data  output  WORD_W  assembled random word, stable while rnd_valid
- rnd_valid  output  1  word available
- rnd_ready  input  1  consumer accepts word when high with rnd_valid
- alarm  output  1  health-test failure, sticky until en low or reset

## Operation
- Each ent_in bit passes through SYNC_STAGES flops. raw = XOR of (sync & ch_mask), registered. All-zero mask gives raw = 0.
- Health test, running whenever en = 1 (all states except IDLE): run counter counts consecutive equal raw bits (saturating 8 bits). A change of raw reloads the counter with 1. When the counter reaches REP_LIMIT, alarm is set.
- FSM states:
  - IDLE: en = 0. Clears the word, bit count, pair phase and run counter. en = 1 -> FILL.
  - FILL: accepts debiased bits. The accumulator shifts left and the new bit enters at the LSB. The WORD_W-th bit transfers the word to rnd_data -> FULL.
  - FULL: rnd_valid = 1 and collection is paused; incoming bits are discarded. valid & ready -> FILL with bit count 0 and pair phase 0.
  - FAIL: entered from FILL or FULL when alarm sets. rnd_valid = 0, rnd_data = 0.
- en = 0 from any state -> IDLE next cycle. FAIL leaves only via IDLE.
- Alarm takes priority: if alarm sets in the same cycle as a handshake or word completion, the state goes to FAIL and the word is lost.
- The consumer must not assume rnd_data holds after rnd_valid falls.

## Timing
- Reset values: rnd_data = 0, rnd_valid = 0, alarm = 0, FSM = IDLE, all counters 0, synchronisers 0.
- Latency from ent_in to raw is SYNC_STAGES + 1 cycles.
- Debiased bit rate is at most one bit per 2 cycles, so a word takes at least 2·WORD_W cycles in FILL.
- rnd_valid rises the cycle after the last bit is accepted.
- Alarm is registered: it rises the cycle after the run counter reaches REP_LIMIT, and the FSM is in FAIL the same cycle alarm rises.
- rnd_ready is ignored when rnd_valid = 0. Back-to-back handshakes are impossible by construction.
- Reset mid-word discards the partial accumulator.

## Configuration
- TRNG_VN_EN defined: von Neumann debiasing on raw pairs.
  - The pair phase toggles every FILL cycle.
  - 01 emits 0, 10 emits 1, 00 and 11 emit nothing.
  - Pair phase resets to 0 on entry to FILL.
- TRNG_VN_EN undefined: every raw bit in FILL is accepted directly, one bit per cycle. A word completes in WORD_W cycles.

## Structure
- trng_pkg holds:
  - state enum (IDLE, FILL, FULL, FAIL)
  - run counter width constant (8)
  - parameter range check constants
- Sub-module trng_rep_test contains the run counter and the sticky alarm. Inputs: clk, rst_n, clr, raw. Parameter: REP_LIMIT.
- The synchroniser is a generate loop inside trng_harvester, not a separate module.

## Test plan
- N_CH = 1, mask = 1, TRNG_VN_EN, ent_in alternating 0,1 per cycle, rnd_ready = 1 -> every word is 0x00, no alarm.
- Same setup with the pattern 1,0 -> words are 0xFF. Patterns 1,1 and 0,0 pairs produce no bits, so rnd_valid stays 0.
- N_CH = 4, mask = 4'b0000, en = 1 -> alarm = 1 REP_LIMIT + 1 cycles after raw settles, FSM in FAIL, rnd_valid = 0. Dropping en clears alarm.
- VN undefined, ent_in[0] drives 1,0,1,1,0,0,1,0, rnd_ready = 0 -> rnd_valid holds with rnd_data = 0xB2 for 20 cycles. rnd_ready = 1 for 1 cycle -> valid falls next cycle.
- rst_n pulsed low after 5 bits of a word -> all outputs 0 immediately. After release the next word is built from fresh bits only.
- mask = 4'b1010 with ent_in[1] toggling and ent_in[3] held 1 -> raw equals ~ent_in[1] delayed SYNC_STAGES + 1 cycles. The masked-off channels do not affect it.
